board_renderer: RTL and testbench



---
 rtl/tetris_pkg.sv | 34 +++
 rtl/board_renderer_if.sv | 10 +
 rtl/board_renderer_cell_classifier.sv | 36 +++
 rtl/board_renderer.sv | 178 +++++++++++++++++
 tb/tb_board_renderer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, pixel colours, cell classes
// and the renderer FSM state encoding.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 23;

   localparam logic [2:0] COL_EMPTY  = 3'b000;
   localparam logic [2:0] COL_FILLED = 3'b011;
   localparam logic [2:0] COL_PIECE  = 3'b110;
   localparam logic [2:0] COL_GRID   = 3'b001;

   typedef enum logic [1:0] {
      CELL_EMPTY  = 2'd0,
      CELL_FILLED = 2'd1,
      CELL_PIECE  = 2'd2
   } cell_class_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } render_state_e;

   // Map a cell class onto the pixel colour drawn for it.
   function automatic logic [2:0] class_colour(input cell_class_e cls);
      case (cls)
         CELL_PIECE:  return COL_PIECE;
         CELL_FILLED: return COL_FILLED;
         default:     return COL_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Pixel plot stream from the board renderer to the VGA adapter.
interface board_renderer_if;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot;

   modport master (output vga_x, vga_y, colour, plot);
   modport slave  (input  vga_x, vga_y, colour, plot);
endinterface

// File: rtl/board_renderer_cell_classifier.sv
// Combinational classification of one board cell as empty, settled block
// or part of the active piece. Off-board piece coordinates never match.
module cell_classifier
   import tetris_pkg::*;
(
   input  logic [4:0]                 row,
   input  logic [3:0]                 col,
   input  logic [BOARD_W*BOARD_H-1:0] snapshot,
   input  logic [3:0][3:0]            piece_x,
   input  logic [3:0][4:0]            piece_y,
   output cell_class_e                cell_class
);

   logic [3:0] hit;
   logic [8:0] bit_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit
         assign hit[gi] = (piece_y[gi] == row) && (piece_x[gi] == col);
      end
   endgenerate

   assign bit_idx = 9'(row) * 9'd10 + 9'(col);

   // Active piece takes priority over a settled block in the same cell
   always_comb begin
      cell_class = CELL_EMPTY;
      if (|hit) begin
         cell_class = CELL_PIECE;
      end else if ((bit_idx < 9'(BOARD_W * BOARD_H)) && snapshot[bit_idx[7:0]]) begin
         cell_class = CELL_FILLED;
      end
   end

endmodule

// File: rtl/board_renderer.sv
// Frame renderer: snapshots the board and active piece on start, then
// streams one pixel per cycle for the visible rows, followed by a done pulse.
// Optional blue grid lines on each cell's last pixel row/column are enabled
// by defining BOARD_RENDERER_GRID_LINES_EN.
module board_renderer
   import tetris_pkg::*;
#(
   parameter int         VISIBLE_ROWS = 20,
   parameter int         CELL_PX      = 4,
   parameter logic [7:0] ORIGIN_X     = 8'd60,
   parameter logic [6:0] ORIGIN_Y     = 7'd20
)(
   input  logic                       clock_framerate,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [BOARD_W*BOARD_H-1:0] board_flattened,
   input  logic [3:0]                 block1_x,
   input  logic [3:0]                 block2_x,
   input  logic [3:0]                 block3_x,
   input  logic [3:0]                 block4_x,
   input  logic [4:0]                 block1_y,
   input  logic [4:0]                 block2_y,
   input  logic [4:0]                 block3_y,
   input  logic [4:0]                 block4_y,
   output logic                       busy,
   output logic                       done,
   board_renderer_if.master           pix
);

   localparam int         PX_W = $clog2(CELL_PX);
   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] DRAW = ST_DRAW;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]                 state_q, state_d;
   logic [PX_W-1:0]            px_q, px_d, py_q, py_d;
   logic [3:0]                 col_q, col_d;
   logic [4:0]                 row_q, row_d;
   logic [BOARD_W*BOARD_H-1:0] snap_q, snap_d;
   logic [3:0][3:0]            piece_x_q, piece_x_d;
   logic [3:0][4:0]            piece_y_q, piece_y_d;
   logic [7:0]                 vga_x_q, vga_x_d;
   logic [6:0]                 vga_y_q, vga_y_d;
   logic [2:0]                 colour_q, colour_d;
   logic                       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

   logic        px_last, py_last, col_last, row_last;
   logic [8:0]  x_wide, y_wide;
   cell_class_e cell_class;

   assign px_last  = (px_q == PX_W'(CELL_PX - 1));
   assign py_last  = (py_q == PX_W'(CELL_PX - 1));
   assign col_last = (col_q == 4'd9);
   assign row_last = (row_q == 5'(VISIBLE_ROWS - 1));

   // Sequencing: latch the snapshot on start, then walk px, py, col, row
   always_comb begin
      state_d   = state_q;
      px_d      = px_q;
      py_d      = py_q;
      col_d     = col_q;
      row_d     = row_q;
      snap_d    = snap_q;
      piece_x_d = piece_x_q;
      piece_y_d = piece_y_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = DRAW;
               px_d      = '0;
               py_d      = '0;
               col_d     = '0;
               row_d     = '0;
               snap_d    = board_flattened;
               piece_x_d = {block4_x, block3_x, block2_x, block1_x};
               piece_y_d = {block4_y, block3_y, block2_y, block1_y};
            end
         end
         DRAW: begin
            px_d = px_q + PX_W'(1);
            if (px_last) begin
               px_d = '0;
               py_d = py_q + PX_W'(1);
               if (py_last) begin
                  py_d  = '0;
                  col_d = col_q + 4'd1;
                  if (col_last) begin
                     col_d = '0;
                     row_d = row_q + 5'd1;
                     if (row_last) begin
                        row_d   = '0;
                        state_d = DONE;
                     end
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so classify the pixel the counters are about to hold
   cell_classifier u_classifier (
      .row        (row_d),
      .col        (col_d),
      .snapshot   (snap_d),
      .piece_x    (piece_x_d),
      .piece_y    (piece_y_d),
      .cell_class (cell_class)
   );

   assign x_wide = 9'(ORIGIN_X) + 9'(col_d) * 9'(CELL_PX) + 9'(px_d);
   assign y_wide = 9'(ORIGIN_Y) + (9'(VISIBLE_ROWS - 1) - 9'(row_d)) * 9'(CELL_PX) + 9'(py_d);

   // Pixel and status outputs for the upcoming cycle
   always_comb begin
      plot_d   = (state_d == DRAW);
      done_d   = (state_d == DONE);
      busy_d   = (state_d != IDLE);
      vga_x_d  = '0;
      vga_y_d  = '0;
      colour_d = COL_EMPTY;
      if (plot_d) begin
         vga_x_d  = x_wide[7:0];
         vga_y_d  = y_wide[6:0];
         colour_d = class_colour(cell_class);
`ifdef BOARD_RENDERER_GRID_LINES_EN
         if ((px_d == PX_W'(CELL_PX - 1)) || (py_d == PX_W'(CELL_PX - 1))) begin
            colour_d = COL_GRID;
         end
`endif
      end
   end

   // State, snapshot and output registers; reset aborts any frame in progress
   always_ff @(posedge clock_framerate) begin
      if (!resetn) begin
         state_q   <= IDLE;
         px_q      <= '0;
         py_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         snap_q    <= '0;
         piece_x_q <= '0;
         piece_y_q <= '0;
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         colour_q  <= '0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         px_q      <= px_d;
         py_q      <= py_d;
         col_q     <= col_d;
         row_q     <= row_d;
         snap_q    <= snap_d;
         piece_x_q <= piece_x_d;
         piece_y_q <= piece_y_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pix.vga_x  = vga_x_q;
   assign pix.vga_y  = vga_y_q;
   assign pix.colour = colour_q;
   assign pix.plot   = plot_q;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: a frame model pushes every
// expected pixel into a queue on start; each plotted pixel pops and compares.
module tb_board_renderer;

   localparam int ROWS = 20;
   localparam int CPX  = 4;
   localparam int OX   = 60;
   localparam int OY   = 20;
   localparam int FRAME_PLOTS = 10 * ROWS * CPX * CPX;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [229:0] board_r = '0;
   logic [3:0]   bx [4];
   logic [4:0]   by [4];
   logic         busy, done;

   board_renderer_if pix ();

   board_renderer dut (
      .clock_framerate (clk),
      .resetn          (resetn),
      .start           (start),
      .board_flattened (board_r),
      .block1_x        (bx[0]),
      .block2_x        (bx[1]),
      .block3_x        (bx[2]),
      .block4_x        (bx[3]),
      .block1_y        (by[0]),
      .block2_y        (by[1]),
      .block3_y        (by[2]),
      .block4_y        (by[3]),
      .busy            (busy),
      .done            (done),
      .pix             (pix)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [17:0] sb [$];
   int          plot_total = 0;
   int          done_total = 0;
   int          yellow_cnt = 0;
   logic [2:0]  p76_20, p60_96, p63_99, p96_96;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and score whatever the DUT presents at the falling edge
   task automatic tick();
      logic [17:0] exp_pix;
      @(negedge clk);
      if (done) done_total++;
      if (pix.plot) begin
         plot_total++;
         if (pix.colour == 3'b110) yellow_cnt++;
         if (pix.vga_x == 8'd76 && pix.vga_y == 7'd20) p76_20 = pix.colour;
         if (pix.vga_x == 8'd60 && pix.vga_y == 7'd96) p60_96 = pix.colour;
         if (pix.vga_x == 8'd63 && pix.vga_y == 7'd99) p63_99 = pix.colour;
         if (pix.vga_x == 8'd96 && pix.vga_y == 7'd96) p96_96 = pix.colour;
         if (sb.size() == 0) begin
            chk("sb_empty_at_plot", 32'(sb.size()), 32'd1);
         end else begin
            exp_pix = sb.pop_front();
            chk("pixel", 32'({pix.vga_x, pix.vga_y, pix.colour}), 32'(exp_pix));
         end
      end
   endtask

   // Push the expected pixel stream for the current inputs, in scan order
   task automatic push_frame();
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      bit         hit;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < 10; c++)
            for (int y = 0; y < CPX; y++)
               for (int x = 0; x < CPX; x++) begin
                  ex  = 8'(OX + c * CPX + x);
                  ey  = 7'(OY + (ROWS - 1 - r) * CPX + y);
                  hit = 1'b0;
                  for (int k = 0; k < 4; k++)
                     if (int'(by[k]) == r && int'(bx[k]) == c) hit = 1'b1;
                  ec = hit ? 3'b110 : (board_r[r * 10 + c] ? 3'b011 : 3'b000);
`ifdef BOARD_RENDERER_GRID_LINES_EN
                  if (x == CPX - 1 || y == CPX - 1) ec = 3'b001;
`endif
                  sb.push_back({ex, ey, ec});
               end
   endtask

   task automatic clear_marks();
      p76_20 = 3'b111;
      p60_96 = 3'b111;
      p63_99 = 3'b111;
      p96_96 = 3'b111;
      yellow_cnt = 0;
   endtask

   // Tick until done is seen or the budget runs out; returns ticks taken
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < FRAME_PLOTS + 100) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   // Tick until the given number of plots of the current frame has been seen
   task automatic wait_plots(input int base, input int target);
      int n;
      n = 0;
      while ((plot_total - base) < target && n < FRAME_PLOTS + 100) begin
         tick();
         n++;
      end
      chk("plot_count_reached", 32'(plot_total - base), 32'(target));
   endtask

   // Start one frame with the current inputs and score it through to done
   task automatic run_frame(input string tag);
      int base, n;
      clear_marks();
      base = plot_total;
      start = 1'b1;
      push_frame();
      tick();
      start = 1'b0;
      chk({tag, "_first_plot"}, 32'(pix.plot), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({tag, "_done_cycle"}, 32'(n + 1), 32'(FRAME_PLOTS + 1));
      chk({tag, "_frame_len"}, 32'(plot_total - base), 32'(FRAME_PLOTS));
      chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
      chk({tag, "_done_plot_low"}, 32'(pix.plot), 32'd0);
      tick();
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      $display("frame %s: plots=%0d done_after=%0d", tag, plot_total - base, n + 1);
   endtask

   task automatic set_piece(input int k, input int x, input int y);
      bx[k] = 4'(x);
      by[k] = 5'(y);
   endtask

   initial begin
      int base, n, dbase;
      for (int k = 0; k < 4; k++) set_piece(k, 0, 22);

      // Reset state
      repeat (3) tick();
      chk("rst_plot", 32'(pix.plot), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vga_x", 32'(pix.vga_x), 32'd0);
      chk("rst_vga_y", 32'(pix.vga_y), 32'd0);
      chk("rst_colour", 32'(pix.colour), 32'd0);
      $display("reset: plot=%0b busy=%0b done=%0b", pix.plot, busy, done);
      resetn = 1'b1;
      tick();

      // Empty board with a T-ish piece at the top of the well
      board_r = '0;
      set_piece(0, 4, 19);
      set_piece(1, 4, 18);
      set_piece(2, 5, 19);
      set_piece(3, 3, 19);
      run_frame("piece_top");
      chk("piece_px_76_20", 32'(p76_20), 32'b110);
`ifdef BOARD_RENDERER_GRID_LINES_EN
      chk("piece_yellow_cnt", 32'(yellow_cnt), 32'd36);
`else
      chk("piece_yellow_cnt", 32'(yellow_cnt), 32'd64);
`endif

      // Single settled block at row 0 col 0, piece parked in the spawn area
      board_r = '0;
      board_r[0] = 1'b1;
      for (int k = 0; k < 4; k++) set_piece(k, k, 21);
      run_frame("corner_block");
      chk("corner_px_60_96", 32'(p60_96), 32'b011);
`ifdef BOARD_RENDERER_GRID_LINES_EN
      chk("corner_px_63_99", 32'(p63_99), 32'b001);
`else
      chk("corner_px_63_99", 32'(p63_99), 32'b011);
`endif
      chk("hidden_piece_no_yellow", 32'(yellow_cnt), 32'd0);

      // Random board, piece partly off the right edge (x>9 invisible)
      for (int w = 0; w < 8; w++) board_r[w * 32 +: 32] = $urandom;
      board_r[229:224] = 6'($urandom);
      set_piece(0, 12, 5);
      set_piece(1, 9, 5);
      set_piece(2, 8, 5);
      set_piece(3, 15, 0);
      run_frame("random_board");

      // start held high across a whole frame: exactly one restart after IDLE
      board_r = '0;
      board_r[19:10] = 10'h3ff;
      set_piece(0, 0, 0);
      set_piece(1, 1, 0);
      set_piece(2, 2, 0);
      set_piece(3, 3, 0);
      base = plot_total;
      start = 1'b1;
      push_frame();
      tick();
      wait_done(n);
      chk("held_first_len", 32'(plot_total - base), 32'(FRAME_PLOTS));
      push_frame();
      tick();
      chk("held_gap_plot", 32'(pix.plot), 32'd0);
      chk("held_gap_done", 32'(done), 32'd0);
      tick();
      chk("held_restart_plot", 32'(pix.plot), 32'd1);
      start = 1'b0;
      wait_done(n);
      chk("held_total_len", 32'(plot_total - base), 32'(2 * FRAME_PLOTS));
      chk("held_sb_drained", 32'(sb.size()), 32'd0);
      tick();
      chk("held_idle_busy", 32'(busy), 32'd0);
      $display("frame held_start: plots=%0d", plot_total - base);

      // Snapshot isolation: inputs change at plot 100 must not show up
      clear_marks();
      board_r = '0;
      set_piece(0, 0, 10);
      set_piece(1, 1, 10);
      set_piece(2, 2, 10);
      set_piece(3, 3, 10);
      base = plot_total;
      start = 1'b1;
      push_frame();
      tick();
      start = 1'b0;
      wait_plots(base, 100);
      board_r[9] = 1'b1;
      set_piece(0, 9, 0);
      wait_done(n);
      chk("iso_frame_len", 32'(plot_total - base), 32'(FRAME_PLOTS));
      chk("iso_px_96_96", 32'(p96_96), 32'b000);
      chk("iso_sb_drained", 32'(sb.size()), 32'd0);
      tick();
      $display("frame snapshot_isolation: plots=%0d", plot_total - base);

      // Reset in the middle of a frame aborts it with no done pulse
      board_r = '0;
      board_r[55] = 1'b1;
      base = plot_total;
      start = 1'b1;
      push_frame();
      tick();
      start = 1'b0;
      wait_plots(base, 1500);
      resetn = 1'b0;
      tick();
      chk("abort_plot", 32'(pix.plot), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      sb.delete();
      resetn = 1'b1;
      dbase = done_total;
      repeat (FRAME_PLOTS + 100) tick();
      chk("abort_no_done", 32'(done_total - dbase), 32'd0);
      $display("frame reset_abort: plots_before_abort=%0d", 1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
